switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Conditions the four raw push-button inputs before they reach the display-mode state machine. That state machine consumes debounced levels and detects its own edges.
- Per channel: 2-flop synchroniser, then a 4-state confirm FSM with a shared-width stability counter.
- Outputs: a clean level bus, plus one-cycle press and release pulses for downstream consumers that want strobes.
- All channels are identical and fully independent.

Parameters:
g_DEBOUNCE_CYCLES, 250000, synchronised input must hold a new value this many consecutive cycles before commit (10 ms at 25 MHz); legal range 1 to 2^24.
g_NUM_SWITCHES, 4, number of independent channels.

Ports:
i_Clk  input  1  system clock; all logic on its rising edge.
i_Reset  input  1  asynchronous, active-high reset.
i_Switches  input  g_NUM_SWITCHES  raw, asynchronous, bouncing switch levels (1 = pressed).
o_Switches  output  g_NUM_SWITCHES  debounced level per channel.
o_Pressed  output  g_NUM_SWITCHES  1-cycle pulse when a channel commits 0->1.
o_Released  output  g_NUM_SWITCHES  1-cycle pulse when a channel commits 1->0.

Behaviour:
- Reset (async assert, sync release):
  - Sync flops = 0; FSM = IDLE_LOW; counter = 0.
  - o_Switches = 0, o_Pressed = 0, o_Released = 0.
- Synchroniser: r_Sync1 <= i_Switches[n]; r_Sync2 <= r_Sync1. Only r_Sync2 (S) feeds the FSM.
- Counter width: clog2(g_DEBOUNCE_CYCLES), minimum 1 bit. Never wraps, because it is cleared on every state entry.
- FSM states and transitions, per channel:
  - IDLE_LOW: o_Switches[n] = 0. S = 1 -> CONFIRM_HIGH, counter <= 0.
  - CONFIRM_HIGH:
    - S = 0 -> IDLE_LOW (abort), counter <= 0.
    - Else if counter == g_DEBOUNCE_CYCLES-1 -> IDLE_HIGH, o_Switches[n] <= 1, o_Pressed[n] <= 1.
    - Else counter + 1.
  - IDLE_HIGH: o_Switches[n] = 1. S = 0 -> CONFIRM_LOW, counter <= 0.
  - CONFIRM_LOW: mirror of CONFIRM_HIGH. Commit sets o_Switches[n] <= 0 and o_Released[n] <= 1.
  - Unreachable encodings -> IDLE_LOW, outputs 0.
- Pulses:
  - o_Pressed and o_Released are registered and high for exactly one cycle, in the same cycle o_Switches changes.
  - Never both high on one channel in the same cycle.
- Latency:
  - Raw edge first sampled at edge E0; S changes after E1; FSM enters CONFIRM at E2; commit at E(g_DEBOUNCE_CYCLES+2).
  - So o_Switches changes g_DEBOUNCE_CYCLES+3 rising edges after the first sampling edge.
- Glitches:
  - Any S return to the committed value during CONFIRM aborts; the count restarts from 0 on the next departure.
  - Pulses shorter than g_DEBOUNCE_CYCLES cycles at S never propagate.
- g_DEBOUNCE_CYCLES = 1: commit on the cycle after entering CONFIRM, if S is still different.
- Reset mid-CONFIRM or in IDLE_HIGH:
  - Immediate return to reset values.
  - No release pulse is generated.
  - If the switch is still held after reset release, a full press confirm follows.
- Simultaneous activity on several channels: each commits on its own schedule; multiple o_Pressed bits may assert in the same cycle.

Test Plan:
- g_DEBOUNCE_CYCLES=4; reset asserted 3 cycles then released -> all outputs 0; no pulses for 20 idle cycles.
- D=4; i_Switches[0] 0->1 held -> o_Switches[0]=1 and o_Pressed=4'b0001 exactly 7 edges after the first sampling edge, then o_Pressed=0; release held -> o_Released=4'b0001 for 1 cycle, 7 edges later.
- D=4; i_Switches[1] pulsed high 3 cycles, low 1, high 3, then low -> o_Switches[1] stays 0; no pulses at any point.
- D=4; i_Switches[2] and [3] rise on the same edge -> both commit in the same cycle; o_Pressed=4'b1100 for one cycle.
- D=4; i_Switches[0] high; i_Reset pulsed mid-CONFIRM (2 cycles after S rises); switch kept high -> outputs 0 during reset; o_Pressed[0] fires 7 edges after reset release; no o_Released.
- D=1; single-cycle raw high -> no commit; 2-cycle raw high -> commit with o_Pressed pulse 4 edges after the first sampling edge.

Source files
------------

// File: rtl/switch_debouncer.sv
// Push-button conditioner: per-channel two-flop synchroniser feeding a confirm FSM
// that commits a new level only after it has been stable long enough.
module switch_debouncer #(
    parameter int g_DEBOUNCE_CYCLES = 250000,
    parameter int g_NUM_SWITCHES    = 4
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic [g_NUM_SWITCHES-1:0] i_Switches,
    output logic [g_NUM_SWITCHES-1:0] o_Switches,
    output logic [g_NUM_SWITCHES-1:0] o_Pressed,
    output logic [g_NUM_SWITCHES-1:0] o_Released
);

    localparam int CNT_W = (g_DEBOUNCE_CYCLES > 1) ? $clog2(g_DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(g_DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW     = 2'b00,
        CONFIRM_HIGH = 2'b01,
        IDLE_HIGH    = 2'b10,
        CONFIRM_LOW  = 2'b11
    } state_t;

    genvar n;
    generate
        for (n = 0; n < g_NUM_SWITCHES; n++) begin : g_chan
            logic             sync1;
            logic             sync2;
            state_t           state;
            state_t           state_next;
            logic [CNT_W-1:0] count;
            logic [CNT_W-1:0] count_next;
            logic             level;
            logic             level_next;
            logic             pressed;
            logic             pressed_next;
            logic             released;
            logic             released_next;

            // Bring the asynchronous raw level into the clock domain.
            always_ff @(posedge i_Clk or posedge i_Reset) begin
                if (i_Reset) begin
                    sync1 <= 1'b0;
                    sync2 <= 1'b0;
                end else begin
                    sync1 <= i_Switches[n];
                    sync2 <= sync1;
                end
            end

            // FSM state, stability counter and registered outputs.
            always_ff @(posedge i_Clk or posedge i_Reset) begin
                if (i_Reset) begin
                    state    <= IDLE_LOW;
                    count    <= '0;
                    level    <= 1'b0;
                    pressed  <= 1'b0;
                    released <= 1'b0;
                end else begin
                    state    <= state_next;
                    count    <= count_next;
                    level    <= level_next;
                    pressed  <= pressed_next;
                    released <= released_next;
                end
            end

            // Next-state logic; the counter is cleared on every state entry so it never wraps.
            always_comb begin
                state_next    = state;
                count_next    = count;
                level_next    = level;
                pressed_next  = 1'b0;
                released_next = 1'b0;
                case (state)
                    IDLE_LOW: begin
                        level_next = 1'b0;
                        if (sync2) begin
                            state_next = CONFIRM_HIGH;
                            count_next = '0;
                        end else begin
                            state_next = IDLE_LOW;
                        end
                    end
                    CONFIRM_HIGH: begin
                        level_next = 1'b0;
                        if (!sync2) begin
                            state_next = IDLE_LOW;
                            count_next = '0;
                        end else if (count == CNT_LAST) begin
                            state_next   = IDLE_HIGH;
                            count_next   = '0;
                            level_next   = 1'b1;
                            pressed_next = 1'b1;
                        end else begin
                            count_next = count + CNT_W'(1);
                        end
                    end
                    IDLE_HIGH: begin
                        level_next = 1'b1;
                        if (!sync2) begin
                            state_next = CONFIRM_LOW;
                            count_next = '0;
                        end else begin
                            state_next = IDLE_HIGH;
                        end
                    end
                    CONFIRM_LOW: begin
                        level_next = 1'b1;
                        if (sync2) begin
                            state_next = IDLE_HIGH;
                            count_next = '0;
                        end else if (count == CNT_LAST) begin
                            state_next    = IDLE_LOW;
                            count_next    = '0;
                            level_next    = 1'b0;
                            released_next = 1'b1;
                        end else begin
                            count_next = count + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_next = IDLE_LOW;
                        count_next = '0;
                        level_next = 1'b0;
                    end
                endcase
            end

            assign o_Switches[n] = level;
            assign o_Pressed[n]  = pressed;
            assign o_Released[n] = released;
        end
    endgenerate

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed vector table on a D=4 and a D=1 instance,
// then randomized switch activity checked every cycle against a run-length model.
module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst4;
    logic       rst1;
    logic [3:0] sw4;
    logic [3:0] sw1;
    logic [3:0] lvl4, pr4, rl4;
    logic [3:0] lvl1, pr1, rl1;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    switch_debouncer #(.g_DEBOUNCE_CYCLES(4), .g_NUM_SWITCHES(4)) dut4 (
        .i_Clk(clk), .i_Reset(rst4), .i_Switches(sw4),
        .o_Switches(lvl4), .o_Pressed(pr4), .o_Released(rl4)
    );

    switch_debouncer #(.g_DEBOUNCE_CYCLES(1), .g_NUM_SWITCHES(4)) dut1 (
        .i_Clk(clk), .i_Reset(rst1), .i_Switches(sw1),
        .o_Switches(lvl1), .o_Pressed(pr1), .o_Released(rl1)
    );

    typedef struct {
        bit         sel;
        bit         rst;
        logic [3:0] sw;
        logic [3:0] esw;
        logic [3:0] epr;
        logic [3:0] erl;
    } vec_t;

    vec_t vecs[$];

    // Reference model: a new level commits once the (two-cycle delayed) input has
    // differed from the committed level on D+1 consecutive clock edges.
    int         dcyc[2] = '{4, 1};
    logic [3:0] m_h1[2];
    logic [3:0] m_h2[2];
    logic [3:0] m_lvl[2];
    logic [3:0] m_pr[2];
    logic [3:0] m_rl[2];
    int         m_run[2][4];

    function automatic void add(bit sel, bit rst, logic [3:0] sw,
                                logic [3:0] esw, logic [3:0] epr, logic [3:0] erl);
        vec_t v;
        v.sel = sel; v.rst = rst; v.sw = sw; v.esw = esw; v.epr = epr; v.erl = erl;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int d, logic [3:0] got, logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut_d%0d got=%b exp=%b at %0t", name, dcyc[d], got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit         rst;
        logic [3:0] raw;
        logic       s;
        for (int d = 0; d < 2; d++) begin
            rst = (d == 0) ? rst4 : rst1;
            raw = (d == 0) ? sw4 : sw1;
            m_pr[d] = 4'b0000;
            m_rl[d] = 4'b0000;
            if (rst) begin
                m_h1[d]  = 4'b0000;
                m_h2[d]  = 4'b0000;
                m_lvl[d] = 4'b0000;
                for (int n = 0; n < 4; n++) m_run[d][n] = 0;
            end else begin
                for (int n = 0; n < 4; n++) begin
                    s = m_h2[d][n];
                    if (s != m_lvl[d][n]) begin
                        m_run[d][n]++;
                        if (m_run[d][n] == dcyc[d] + 1) begin
                            m_lvl[d][n] = s;
                            if (s) m_pr[d][n] = 1'b1;
                            else   m_rl[d][n] = 1'b1;
                            m_run[d][n] = 0;
                        end
                    end else begin
                        m_run[d][n] = 0;
                    end
                end
                m_h2[d] = m_h1[d];
                m_h1[d] = raw;
            end
        end
    endtask

    task automatic check_model();
        chk("model_level",    0, lvl4, m_lvl[0]);
        chk("model_pressed",  0, pr4,  m_pr[0]);
        chk("model_released", 0, rl4,  m_rl[0]);
        chk("model_level",    1, lvl1, m_lvl[1]);
        chk("model_pressed",  1, pr1,  m_pr[1]);
        chk("model_released", 1, rl1,  m_rl[1]);
    endtask

    // One clock: inputs already driven; model follows the edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic [3:0] nv;
        int         hold[2][4];
        int         val[2][4];

        rst4 = 1'b1; rst1 = 1'b1; sw4 = 4'b0000; sw1 = 4'b0000;
        for (int d = 0; d < 2; d++) begin
            m_h1[d] = 4'b0000; m_h2[d] = 4'b0000; m_lvl[d] = 4'b0000;
            m_pr[d] = 4'b0000; m_rl[d] = 4'b0000;
            for (int n = 0; n < 4; n++) begin
                m_run[d][n] = 0; hold[d][n] = 0; val[d][n] = 0;
            end
        end

        // D=4: reset, then idle
        for (int i = 0; i < 3; i++)  add(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 20; i++) add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // channel 0 press and release
        for (int i = 0; i < 6; i++)  add(1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        for (int i = 0; i < 3; i++)  add(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++)  add(1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        for (int i = 0; i < 3; i++)  add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // channel 1 glitches shorter than the confirm window
        for (int i = 0; i < 3; i++)  add(1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++)  add(1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++)  add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // channels 2 and 3 together
        for (int i = 0; i < 6; i++)  add(1'b0, 1'b0, 4'b1100, 4'b0000, 4'b0000, 4'b0000);
        add(1'b0, 1'b0, 4'b1100, 4'b1100, 4'b1100, 4'b0000);
        add(1'b0, 1'b0, 4'b1100, 4'b1100, 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++)  add(1'b0, 1'b0, 4'b0000, 4'b1100, 4'b0000, 4'b0000);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1100);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // reset while channel 0 is confirming, switch still held afterwards
        for (int i = 0; i < 4; i++)  add(1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++)  add(1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        add(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        // reset while committed high: level drops, no release strobe
        add(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++)  add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // D=1: reset, one-cycle pulse rejected, two-cycle pulse commits
        for (int i = 0; i < 2; i++)  add(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 2; i++)  add(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++)  add(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 2; i++)  add(1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add(1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        for (int i = 0; i < 3; i++)  add(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        foreach (vecs[i]) begin
            if (vecs[i].sel == 1'b0) begin
                rst4 = vecs[i].rst; sw4 = vecs[i].sw;
            end else begin
                rst1 = vecs[i].rst; sw1 = vecs[i].sw;
            end
            cycle();
            if (vecs[i].sel == 1'b0) begin
                chk($sformatf("tbl%0d_level", i),    0, lvl4, vecs[i].esw);
                chk($sformatf("tbl%0d_pressed", i),  0, pr4,  vecs[i].epr);
                chk($sformatf("tbl%0d_released", i), 0, rl4,  vecs[i].erl);
            end else begin
                chk($sformatf("tbl%0d_level", i),    1, lvl1, vecs[i].esw);
                chk($sformatf("tbl%0d_pressed", i),  1, pr1,  vecs[i].epr);
                chk($sformatf("tbl%0d_released", i), 1, rl1,  vecs[i].erl);
            end
        end

        // Randomized bouncing with occasional resets on both instances
        for (int c = 0; c < 1200; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int n = 0; n < 4; n++) begin
                    if (hold[d][n] == 0) begin
                        val[d][n]  = int'($urandom_range(0, 1));
                        hold[d][n] = int'($urandom_range(1, 9));
                    end
                    hold[d][n]--;
                    nv[n] = (val[d][n] != 0);
                end
                if (d == 0) begin
                    sw4  = nv;
                    rst4 = ($urandom_range(0, 249) == 0);
                end else begin
                    sw1  = nv;
                    rst1 = ($urandom_range(0, 249) == 0);
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
